temp_alarm_monitor: RTL and testbench
=====================================

// Module: temp_alarm_monitor
// PURPOSE
//  Downstream consumer of the minute-average stage. Captures each new 8-bit
//  average on the minute pulse, tracks running min/max and trend, and runs a
//  debounced hysteresis alarm FSM (high/low) with a sticky latched flag.
//  Drives board LEDs / status register of the temperature subsystem.
// PARAMETERS
//  W         8  width of average and threshold values (unsigned)
//  HYST      2  hysteresis in LSBs applied when leaving an alarm state
//  DEBOUNCE  3  consecutive qualifying samples needed to enter an alarm (>=1)
//  CNT_W     8  width of sample counter (saturating)
// PORTS
//  clk        in   1      system clock
//  rst        in   1      asynchronous reset, active-high
//  avg_in     in   W      minute average from the averaging stage
//  min_p      in   1      minute pulse from the averaging stage (level, >=1 cycle)
//  thr_high   in   W      high alarm threshold (alarm when avg > thr_high)
//  thr_low    in   W      low alarm threshold (alarm when avg < thr_low)
//  alarm_clr  in   1      clears latched alarm flag and min/max/counter
//  alarm_hi   out  1      in HIGH state
//  alarm_lo   out  1      in LOW state
//  alarm_lat  out  1      sticky: set on any HIGH/LOW entry, cleared by alarm_clr
//  max_avg    out  W      largest captured average since reset/clear
//  min_avg    out  W      smallest captured average since reset/clear
//  trend      out  2      00 flat, 01 rising, 10 falling (vs previous sample)
//  sample_cnt out  CNT_W  samples captured since reset/clear, saturates at max
//  sample_v   out  1      1-cycle strobe: new sample committed this cycle
// BEHAVIOUR
//  Reset: all outputs 0 except min_avg = all-ones; FSM = NORMAL; first_seen=0.
//  Capture: rising edge of min_p detected (registered prev); avg_in sampled one
//   cycle after the edge detect (allows upstream avg register to settle);
//   commit cycle = edge+2, sample_v high that cycle. Held min_p = one sample.
//  Min/max: on commit, max_avg=max(max_avg,s), min_avg=min(min_avg,s).
//  Trend: first sample after reset/clear -> 00; else compare s to prev sample.
//  sample_cnt: +1 on commit, saturates at 2^CNT_W-1.
//  FSM (advances only on commit; deb = debounce counter, reset on state change):
//   NORMAL : s>thr_high -> PEND_HI (deb=1); s<thr_low -> PEND_LO (deb=1).
//            If DEBOUNCE==1 go directly to HIGH/LOW.
//   PEND_HI: s>thr_high -> deb+1; deb reaches DEBOUNCE -> HIGH; else -> NORMAL.
//   PEND_LO: mirror of PEND_HI with s<thr_low -> LOW.
//   HIGH   : s <= thr_high-HYST (saturate at 0) -> NORMAL; stay otherwise.
//            s<thr_low while HIGH -> PEND_LO directly (deb=1).
//   LOW    : s >= thr_low+HYST (saturate at 2^W-1) -> NORMAL; mirror of HIGH.
//  Thresholds compared unsigned, in W+1 bits to avoid wrap; thr_low>thr_high
//   is legal, high check has priority.
//  alarm_hi/alarm_lo registered from state; assert on commit+1.
//  alarm_lat set when entering HIGH or LOW; alarm_clr same cycle as set -> set
//   wins. alarm_clr also resets min/max/cnt/trend-first; FSM unaffected.
//  alarm_clr coincident with commit: clear first, then the sample is applied
//   (counter=1, min=max=s).
//  Async rst mid-capture aborts pending sample; no sample_v afterwards.
// STRUCTURE
//  Package temp_pkg: typedef enum {NORMAL,PEND_HI,PEND_LO,HIGH,LOW} alarm_st_t;
//   trend encoding constants TR_FLAT/TR_RISE/TR_FALL.
//  Sub-module temp_minmax_tracker (min/max/count/trend, clear + commit inputs);
//   FSM and capture pipeline stay in top.
// TESTING
//  1 Reset: rst pulse -> all outputs 0, min_avg=8'hFF, no sample_v.
//  2 Samples 20,25,22 (thr 30/10) -> trend 01 then 10, max=25, min=20, cnt=3,
//    alarm_hi/lo never set; sample_v exactly 2 cycles after each min_p edge.
//  3 Samples 31,32,33 (thr_high=30, DEBOUNCE=3) -> alarm_hi after 3rd, lat=1;
//    then 29 -> stays HIGH; 28 -> NORMAL, lat still 1; alarm_clr -> lat 0.
//  4 Samples 31,29,31 -> never HIGH (debounce broken); 9,9,9 (thr_low=10) ->
//    LOW; 11 -> stays LOW; 12 -> NORMAL.
//  5 min_p held high 10 cycles -> single commit; alarm_clr on commit cycle ->
//    cnt=1, min=max=sample.
//  6 rst asserted one cycle after min_p edge -> no sample_v, state NORMAL;
//    300 samples -> sample_cnt saturates at 255.

Source files
------------

// File: rtl/temp_pkg.sv
// Shared types for the temperature alarm slice.
//   alarm_st_t : alarm FSM states
//   TR_*       : trend output encodings (previous sample vs current)
package temp_pkg;

    typedef enum logic [2:0] {
        NORMAL,
        PEND_HI,
        PEND_LO,
        HIGH,
        LOW
    } alarm_st_t;

    localparam logic [1:0] TR_FLAT = 2'b00;
    localparam logic [1:0] TR_RISE = 2'b01;
    localparam logic [1:0] TR_FALL = 2'b10;

endpackage

// File: rtl/temp_minmax_tracker.sv
// Running statistics over committed samples.
//   clk, rst    : clock, async active-high reset
//   clr         : clear statistics (a same-cycle commit is applied after the clear)
//   commit, s   : sample strobe and value
//   max_avg     : largest sample since reset/clear (0 when empty)
//   min_avg     : smallest sample since reset/clear (all-ones when empty)
//   trend       : current sample vs previous one (flat for the first sample)
//   sample_cnt  : committed samples, saturating
module temp_minmax_tracker
    import temp_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             commit,
    input  logic [W-1:0]     s,
    output logic [W-1:0]     max_avg,
    output logic [W-1:0]     min_avg,
    output logic [1:0]       trend,
    output logic [CNT_W-1:0] sample_cnt
);

    logic [W-1:0] prev_s;
    logic         first_seen;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_avg    <= '0;
            min_avg    <= '1;
            trend      <= TR_FLAT;
            sample_cnt <= '0;
            prev_s     <= '0;
            first_seen <= 1'b0;
        end else if (commit) begin
            // With clr asserted the sample lands on freshly cleared statistics.
            if (clr || !first_seen)
                trend <= TR_FLAT;
            else if (s > prev_s)
                trend <= TR_RISE;
            else if (s < prev_s)
                trend <= TR_FALL;
            else
                trend <= TR_FLAT;

            max_avg <= (clr || s > max_avg) ? s : max_avg;
            min_avg <= (clr || s < min_avg) ? s : min_avg;

            if (clr)
                sample_cnt <= CNT_W'(1);
            else if (sample_cnt != '1)
                sample_cnt <= sample_cnt + CNT_W'(1);

            prev_s     <= s;
            first_seen <= 1'b1;
        end else if (clr) begin
            max_avg    <= '0;
            min_avg    <= '1;
            trend      <= TR_FLAT;
            sample_cnt <= '0;
            first_seen <= 1'b0;
        end
    end

endmodule

// File: rtl/temp_alarm_monitor.sv
// Captures minute averages and runs a debounced hysteresis alarm.
//   clk, rst    : clock, async active-high reset
//   avg_in      : minute average from the averaging stage
//   min_p       : minute pulse (level, one sample per rising edge)
//   thr_high    : alarm when sample > thr_high
//   thr_low     : alarm when sample < thr_low
//   alarm_clr   : clears alarm_lat and the min/max/count/trend statistics
//   alarm_hi/lo : FSM is in HIGH / LOW (visible the cycle after commit)
//   alarm_lat   : sticky flag, set on entry to HIGH or LOW
//   max_avg, min_avg, trend, sample_cnt : running statistics
//   sample_v    : one-cycle strobe on the commit cycle (min_p edge + 2)
module temp_alarm_monitor
    import temp_pkg::*;
#(
    parameter int unsigned W        = 8,
    parameter int unsigned HYST     = 2,
    parameter int unsigned DEBOUNCE = 3,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     avg_in,
    input  logic             min_p,
    input  logic [W-1:0]     thr_high,
    input  logic [W-1:0]     thr_low,
    input  logic             alarm_clr,
    output logic             alarm_hi,
    output logic             alarm_lo,
    output logic             alarm_lat,
    output logic [W-1:0]     max_avg,
    output logic [W-1:0]     min_avg,
    output logic [1:0]       trend,
    output logic [CNT_W-1:0] sample_cnt,
    output logic             sample_v
);

    localparam int unsigned DEB_W   = $clog2(DEBOUNCE + 1);
    localparam logic [W:0]  HYST_X  = (W+1)'(HYST);
    localparam logic [W:0]  W_MAX_X = {1'b0, {W{1'b1}}};

    // ---------------- capture pipeline ----------------
    logic         min_p_q;
    logic         edge_d1;
    logic         commit;
    logic [W-1:0] s_q;
    logic         edge_det;

    assign edge_det = min_p & ~min_p_q;
    assign sample_v = commit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // Reset to 1 so a pulse still high across reset is not re-captured.
            min_p_q <= 1'b1;
            edge_d1 <= 1'b0;
            commit  <= 1'b0;
            s_q     <= '0;
        end else begin
            min_p_q <= min_p;
            edge_d1 <= edge_det;
            commit  <= edge_d1;
            if (edge_d1)
                s_q <= avg_in;
        end
    end

    // ---------------- threshold compares (W+1 bits, no wrap) ----------------
    logic [W:0] s_x, hi_x, lo_x, lo_sum, hi_exit, lo_exit;
    logic       above_hi, below_lo;

    assign s_x      = {1'b0, s_q};
    assign hi_x     = {1'b0, thr_high};
    assign lo_x     = {1'b0, thr_low};
    assign above_hi = s_x > hi_x;
    assign below_lo = s_x < lo_x;
    assign hi_exit  = (hi_x >= HYST_X) ? hi_x - HYST_X : '0;
    assign lo_sum   = lo_x + HYST_X;
    assign lo_exit  = (lo_sum > W_MAX_X) ? W_MAX_X : lo_sum;

    // ---------------- alarm FSM ----------------
    alarm_st_t        state, state_nx;
    logic [DEB_W-1:0] deb, deb_nx, deb_inc;
    logic             enter;

    assign deb_inc = deb + DEB_W'(1);

    always_comb begin
        state_nx = state;
        deb_nx   = deb;
        if (commit) begin
            unique case (state)
                NORMAL: begin
                    if (above_hi) begin
                        state_nx = (DEBOUNCE == 1) ? HIGH : PEND_HI;
                        deb_nx   = DEB_W'(1);
                    end else if (below_lo) begin
                        state_nx = (DEBOUNCE == 1) ? LOW : PEND_LO;
                        deb_nx   = DEB_W'(1);
                    end
                end
                PEND_HI: begin
                    if (above_hi) begin
                        deb_nx = deb_inc;
                        if (deb_inc >= DEB_W'(DEBOUNCE))
                            state_nx = HIGH;
                    end else begin
                        state_nx = NORMAL;
                        deb_nx   = '0;
                    end
                end
                PEND_LO: begin
                    if (below_lo) begin
                        deb_nx = deb_inc;
                        if (deb_inc >= DEB_W'(DEBOUNCE))
                            state_nx = LOW;
                    end else begin
                        state_nx = NORMAL;
                        deb_nx   = '0;
                    end
                end
                HIGH: begin
                    if (below_lo) begin
                        state_nx = (DEBOUNCE == 1) ? LOW : PEND_LO;
                        deb_nx   = DEB_W'(1);
                    end else if (s_x <= hi_exit) begin
                        state_nx = NORMAL;
                        deb_nx   = '0;
                    end
                end
                LOW: begin
                    if (above_hi) begin
                        state_nx = (DEBOUNCE == 1) ? HIGH : PEND_HI;
                        deb_nx   = DEB_W'(1);
                    end else if (s_x >= lo_exit) begin
                        state_nx = NORMAL;
                        deb_nx   = '0;
                    end
                end
                default: begin
                    state_nx = NORMAL;
                    deb_nx   = '0;
                end
            endcase
        end
    end

    assign enter = (state_nx != state) && (state_nx == HIGH || state_nx == LOW);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= NORMAL;
            deb       <= '0;
            alarm_hi  <= 1'b0;
            alarm_lo  <= 1'b0;
            alarm_lat <= 1'b0;
        end else begin
            state    <= state_nx;
            deb      <= deb_nx;
            alarm_hi <= (state_nx == HIGH);
            alarm_lo <= (state_nx == LOW);
            if (enter)
                alarm_lat <= 1'b1;
            else if (alarm_clr)
                alarm_lat <= 1'b0;
        end
    end

    // ---------------- statistics ----------------
    temp_minmax_tracker #(
        .W     (W),
        .CNT_W (CNT_W)
    ) u_tracker (
        .clk        (clk),
        .rst        (rst),
        .clr        (alarm_clr),
        .commit     (commit),
        .s          (s_q),
        .max_avg    (max_avg),
        .min_avg    (min_avg),
        .trend      (trend),
        .sample_cnt (sample_cnt)
    );

endmodule

// File: tb/tb_temp_alarm_monitor.sv
// Directed bench for temp_alarm_monitor (W=8, HYST=2, DEBOUNCE=3, CNT_W=8).
module tb_temp_alarm_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] avg_in;
    logic       min_p;
    logic [7:0] thr_high;
    logic [7:0] thr_low;
    logic       alarm_clr;
    logic       alarm_hi, alarm_lo, alarm_lat;
    logic [7:0] max_avg, min_avg;
    logic [1:0] trend;
    logic [7:0] sample_cnt;
    logic       sample_v;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    temp_alarm_monitor #(
        .W        (8),
        .HYST     (2),
        .DEBOUNCE (3),
        .CNT_W    (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .avg_in     (avg_in),
        .min_p      (min_p),
        .thr_high   (thr_high),
        .thr_low    (thr_low),
        .alarm_clr  (alarm_clr),
        .alarm_hi   (alarm_hi),
        .alarm_lo   (alarm_lo),
        .alarm_lat  (alarm_lat),
        .max_avg    (max_avg),
        .min_avg    (min_avg),
        .trend      (trend),
        .sample_cnt (sample_cnt),
        .sample_v   (sample_v)
    );

    typedef struct {
        logic       clr_before;
        logic [7:0] avg;
        logic       hi;
        logic       lo;
        logic       lat;
        logic [7:0] mx;
        logic [7:0] mn;
        logic [1:0] tr;
        logic [7:0] cnt;
    } vec_t;

    vec_t vt[17];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Raise min_p for 'hold' cycles; expect exactly one sample_v, two cycles
    // after the edge. Optionally pulse alarm_clr on the commit cycle.
    task automatic send(input logic [7:0] v, input int hold, input logic clr_commit);
        int first = -1;
        int n     = 0;
        int last;
        @(negedge clk);
        avg_in = v;
        min_p  = 1'b1;
        last   = ((hold > 3) ? hold : 3) + 3;
        for (int i = 1; i <= last; i++) begin
            @(negedge clk);
            if (i == hold) min_p = 1'b0;
            if (sample_v) begin
                n++;
                if (first < 0) first = i;
            end
            if (clr_commit) begin
                if (i == 2) alarm_clr = 1'b1;
                else if (i == 3) alarm_clr = 1'b0;
            end
        end
        chk("strobe_count", n, 1);
        chk("strobe_delay", first, 2);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        alarm_clr = 1'b1;
        @(negedge clk);
        alarm_clr = 1'b0;
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_hi"},    int'(alarm_hi), 0);
        chk({tag, "_lo"},    int'(alarm_lo), 0);
        chk({tag, "_lat"},   int'(alarm_lat), 0);
        chk({tag, "_max"},   int'(max_avg), 0);
        chk({tag, "_min"},   int'(min_avg), 255);
        chk({tag, "_trend"}, int'(trend), 0);
        chk({tag, "_cnt"},   int'(sample_cnt), 0);
    endtask

    initial begin
        int nstrobe;

        //            clr  avg   hi lo lat max min  tr cnt
        vt[0]  = '{1'b0, 8'd20, 0, 0, 0, 20, 20, 0, 1};
        vt[1]  = '{1'b0, 8'd25, 0, 0, 0, 25, 20, 1, 2};
        vt[2]  = '{1'b0, 8'd22, 0, 0, 0, 25, 20, 2, 3};
        vt[3]  = '{1'b0, 8'd31, 0, 0, 0, 31, 20, 1, 4};
        vt[4]  = '{1'b0, 8'd32, 0, 0, 0, 32, 20, 1, 5};
        vt[5]  = '{1'b0, 8'd33, 1, 0, 1, 33, 20, 1, 6};
        vt[6]  = '{1'b0, 8'd29, 1, 0, 1, 33, 20, 2, 7};
        vt[7]  = '{1'b0, 8'd28, 0, 0, 1, 33, 20, 2, 8};
        vt[8]  = '{1'b1, 8'd31, 0, 0, 0, 31, 31, 0, 1};
        vt[9]  = '{1'b0, 8'd29, 0, 0, 0, 31, 29, 2, 2};
        vt[10] = '{1'b0, 8'd31, 0, 0, 0, 31, 29, 1, 3};
        vt[11] = '{1'b0, 8'd20, 0, 0, 0, 31, 20, 2, 4};
        vt[12] = '{1'b0, 8'd9,  0, 0, 0, 31, 9,  2, 5};
        vt[13] = '{1'b0, 8'd9,  0, 0, 0, 31, 9,  0, 6};
        vt[14] = '{1'b0, 8'd9,  0, 1, 1, 31, 9,  0, 7};
        vt[15] = '{1'b0, 8'd11, 0, 1, 1, 31, 9,  1, 8};
        vt[16] = '{1'b0, 8'd12, 0, 0, 1, 31, 9,  1, 9};

        rst       = 1'b1;
        avg_in    = '0;
        min_p     = 1'b0;
        thr_high  = 8'd30;
        thr_low   = 8'd10;
        alarm_clr = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        nstrobe = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (sample_v) nstrobe++;
        end
        chk("reset_no_strobe", nstrobe, 0);
        chk_cleared("reset");

        // Table: trend/min/max, high alarm with hysteresis, broken debounce, low alarm
        for (int k = 0; k < 17; k++) begin
            if (vt[k].clr_before) begin
                pulse_clr();
                chk($sformatf("v%0d_lat_clr", k), int'(alarm_lat), 0);
            end
            send(vt[k].avg, 1, 1'b0);
            chk($sformatf("v%0d_hi", k),    int'(alarm_hi),   int'(vt[k].hi));
            chk($sformatf("v%0d_lo", k),    int'(alarm_lo),   int'(vt[k].lo));
            chk($sformatf("v%0d_lat", k),   int'(alarm_lat),  int'(vt[k].lat));
            chk($sformatf("v%0d_max", k),   int'(max_avg),    int'(vt[k].mx));
            chk($sformatf("v%0d_min", k),   int'(min_avg),    int'(vt[k].mn));
            chk($sformatf("v%0d_trend", k), int'(trend),      int'(vt[k].tr));
            chk($sformatf("v%0d_cnt", k),   int'(sample_cnt), int'(vt[k].cnt));
        end

        // Clear-only: latched flag and statistics return to empty
        pulse_clr();
        chk_cleared("clr_only");

        // Held min_p gives one sample; clear on the commit cycle keeps the sample
        send(8'd25, 10, 1'b0);
        chk("held_cnt", int'(sample_cnt), 1);
        chk("held_max", int'(max_avg), 25);
        send(8'd15, 1, 1'b1);
        chk("clr_commit_cnt", int'(sample_cnt), 1);
        chk("clr_commit_min", int'(min_avg), 15);
        chk("clr_commit_max", int'(max_avg), 15);
        chk("clr_commit_trend", int'(trend), 0);

        // Reach HIGH, then reset mid-capture
        send(8'd31, 1, 1'b0);
        send(8'd32, 1, 1'b0);
        send(8'd33, 1, 1'b0);
        chk("pre_rst_hi", int'(alarm_hi), 1);
        @(negedge clk);
        avg_in = 8'd77;
        min_p  = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        nstrobe = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 2) min_p = 1'b0;
            if (sample_v) nstrobe++;
        end
        chk("rst_abort_strobe", nstrobe, 0);
        chk_cleared("rst_abort");
        // 29 stays HIGH from HIGH but stays NORMAL from NORMAL
        send(8'd29, 1, 1'b0);
        chk("post_rst_hi", int'(alarm_hi), 0);
        chk("post_rst_cnt", int'(sample_cnt), 1);
        chk("post_rst_max", int'(max_avg), 29);

        // Counter saturation
        pulse_clr();
        for (int i = 1; i <= 300; i++) begin
            send(8'd20, 1, 1'b0);
            if (i == 254) chk("cnt_254", int'(sample_cnt), 254);
            if (i == 255) chk("cnt_255", int'(sample_cnt), 255);
        end
        chk("cnt_sat", int'(sample_cnt), 255);
        chk("sat_hi", int'(alarm_hi), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
